// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet decoder: framing byte, FSM states and error codes.
package uart_pkt_pkg;

   localparam logic [7:0] SOF = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_CMD,
      S_GET_LEN,
      S_GET_PAYLOAD,
      S_GET_CHK
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_CHK     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/uart_packet_decoder.sv
// Frames UART bytes into SOF/CMD/LEN/payload/CHK packets, validates length and XOR checksum,
// and presents good packets as a registered parallel bundle with a one-cycle valid pulse.
module uart_packet_decoder
   import uart_pkt_pkg::*;
#(
   parameter int MAX_PAYLOAD  = 8,
   parameter int BYTE_TIMEOUT = 100_000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic [7:0]               pkt_cmd,
   output logic [3:0]               pkt_len,
   output logic [8*MAX_PAYLOAD-1:0] pkt_payload,
   output logic                     pkt_valid,
   output logic                     pkt_error,
   output logic [1:0]               error_code
);

   localparam int              TW       = $clog2(BYTE_TIMEOUT);
   localparam logic [TW-1:0]   TMO_LAST = TW'(BYTE_TIMEOUT - 1);
   localparam logic [7:0]      MAX_LEN  = 8'(MAX_PAYLOAD);

   state_t                   state, next_state;
   logic [7:0]               chk;
   logic [3:0]               idx;
   logic [7:0]               sh_cmd;
   logic [3:0]               sh_len;
   logic [8*MAX_PAYLOAD-1:0] sh_pay;
   logic [TW-1:0]            tmo_cnt;

   logic                     len_bad;
   logic                     timeout_hit;
   logic                     pkt_good;
   logic                     err_hit;
   logic [1:0]               err_code_d;

   assign len_bad = rx_data > MAX_LEN;
   // A byte arriving on the terminal-count cycle wins over the timeout.
   assign timeout_hit = (state != S_IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (timeout_hit) begin
         next_state = S_IDLE;
      end else if (rx_valid) begin
         unique case (state)
            S_IDLE:        if (rx_data == SOF) next_state = S_GET_CMD;
            S_GET_CMD:     next_state = S_GET_LEN;
            S_GET_LEN: begin
               if (len_bad)              next_state = S_IDLE;
               else if (rx_data == 8'd0) next_state = S_GET_CHK;
               else                      next_state = S_GET_PAYLOAD;
            end
            S_GET_PAYLOAD: if (idx == sh_len - 4'd1) next_state = S_GET_CHK;
            S_GET_CHK:     next_state = S_IDLE;
            default:       next_state = S_IDLE;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      pkt_good   = 1'b0;
      err_hit    = 1'b0;
      err_code_d = ERR_NONE;
      if (timeout_hit) begin
         err_hit    = 1'b1;
         err_code_d = ERR_TIMEOUT;
      end else if (rx_valid && state == S_GET_LEN && len_bad) begin
         err_hit    = 1'b1;
         err_code_d = ERR_LEN;
      end else if (rx_valid && state == S_GET_CHK) begin
         if (rx_data == chk) begin
            pkt_good = 1'b1;
         end else begin
            err_hit    = 1'b1;
            err_code_d = ERR_CHK;
         end
      end
   end

   // NOTE: the shadow buffer is reset explicitly so stale payload never leaks into a shorter packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         chk         <= '0;
         idx         <= '0;
         sh_cmd      <= '0;
         sh_len      <= '0;
         sh_pay      <= '0;
         tmo_cnt     <= '0;
         pkt_cmd     <= '0;
         pkt_len     <= '0;
         pkt_payload <= '0;
         pkt_valid   <= 1'b0;
         pkt_error   <= 1'b0;
         error_code  <= ERR_NONE;
      end else begin
         pkt_valid <= pkt_good;
         pkt_error <= err_hit;
         if (err_hit) error_code <= err_code_d;
         if (pkt_good) begin
            pkt_cmd     <= sh_cmd;
            pkt_len     <= sh_len;
            pkt_payload <= sh_pay;
         end

         if (state == S_IDLE || rx_valid || timeout_hit) tmo_cnt <= '0;
         else                                           tmo_cnt <= tmo_cnt + 1'b1;

         if (rx_valid) begin
            unique case (state)
               S_IDLE: begin
                  if (rx_data == SOF) begin
                     chk    <= '0;
                     idx    <= '0;
                     sh_cmd <= '0;
                     sh_len <= '0;
                     sh_pay <= '0;
                  end
               end
               S_GET_CMD: begin
                  sh_cmd <= rx_data;
                  chk    <= rx_data;
               end
               S_GET_LEN: begin
                  chk <= chk ^ rx_data;
                  if (!len_bad) sh_len <= rx_data[3:0];
               end
               S_GET_PAYLOAD: begin
                  for (int i = 0; i < MAX_PAYLOAD; i++) begin
                     if (idx == 4'(i)) sh_pay[8*i +: 8] <= rx_data;
                  end
                  chk <= chk ^ rx_data;
                  idx <= idx + 4'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
